// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Purpose  : Shared widths and entry type for the writeback arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int WB_DATA_WIDTH_POW = 6;
    localparam int WB_DATA_WIDTH     = 1 << WB_DATA_WIDTH_POW;
    localparam int WB_RD_WIDTH       = 5;
    localparam int WB_FIFO_DEPTH_POW = 2;

    typedef struct packed {
        logic [WB_RD_WIDTH-1:0]   rd;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_entry_t;

    function automatic wb_entry_t wb_make_entry(
        input logic [WB_RD_WIDTH-1:0]   rd,
        input logic [WB_DATA_WIDTH-1:0] data
    );
        wb_entry_t e;
        e.rd   = rd;
        e.data = data;
        return e;
    endfunction

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Purpose  : Synchronous FIFO holding ALU results that lost arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo
    import wb_pkg::*;
#(
    parameter int  FIFO_DEPTH_POW = WB_FIFO_DEPTH_POW,
    parameter type T              = wb_entry_t
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  T                      din_i,
    output T                      head_o,
    output logic [FIFO_DEPTH_POW:0] count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int                  DEPTH     = 1 << FIFO_DEPTH_POW;
    localparam logic [FIFO_DEPTH_POW:0] DEPTH_CNT = (FIFO_DEPTH_POW + 1)'(DEPTH);

    T                          mem_q [DEPTH];
    logic [FIFO_DEPTH_POW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_POW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH_POW:0]   count_q,  count_d;
    logic                      do_push;
    logic                      do_pop;

    assign full_o  = (count_q == DEPTH_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers are exactly FIFO_DEPTH_POW bits, so increment wraps for free.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is readable.
    always_ff @(posedge clk_i) begin
        if (do_push && !rst_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule : wb_fifo
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Merges LSU and ALU results onto the register file write port.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int REG_DATA_WIDTH_POW = WB_DATA_WIDTH_POW,
    parameter int REG_MEM_DEPTH_POW  = WB_RD_WIDTH,
    parameter int FIFO_DEPTH_POW     = WB_FIFO_DEPTH_POW,
    localparam int REG_DATA_WIDTH    = 1 << REG_DATA_WIDTH_POW
) (
    input  logic                         clk_in,
    input  logic                         reset,

    input  logic                         alu_valid_in,
    input  logic [REG_MEM_DEPTH_POW-1:0] alu_rd_in,
    input  logic [REG_DATA_WIDTH-1:0]    alu_data_in,
    output logic                         alu_ready_out,

    input  logic                         lsu_valid_in,
    input  logic [REG_MEM_DEPTH_POW-1:0] lsu_rd_in,
    input  logic [REG_DATA_WIDTH-1:0]    lsu_data_in,

    output logic                         write_en_out,
    output logic [REG_MEM_DEPTH_POW-1:0] rd_out,
    output logic [REG_DATA_WIDTH-1:0]    data_write_out,
    output logic [FIFO_DEPTH_POW:0]      fifo_count_out
);

    wb_entry_t out_q, out_d;
    logic      we_q,  we_d;

    wb_entry_t fifo_head;
    logic      fifo_full;
    logic      fifo_empty;
    logic      fifo_push;
    logic      fifo_pop;

    logic      alu_xfer;
    logic      alu_live;
    logic      lsu_live;
    logic      bypass;

    // Ready depends only on registered occupancy: no same-cycle pop credit.
    assign alu_ready_out = !fifo_full;
    assign alu_xfer      = alu_valid_in && alu_ready_out;

    // rd==0 transfers are accepted but never written nor queued.
    assign alu_live = alu_xfer && (alu_rd_in != '0);
    assign lsu_live = lsu_valid_in && (lsu_rd_in != '0);

    always_comb begin
        we_d     = 1'b0;
        out_d    = out_q;
        fifo_pop = 1'b0;
        bypass   = 1'b0;
        if (lsu_live) begin
            we_d  = 1'b1;
            out_d = wb_make_entry(lsu_rd_in, lsu_data_in);
        end else if (!fifo_empty) begin
            we_d     = 1'b1;
            fifo_pop = 1'b1;
            out_d    = fifo_head;
        end else if (alu_live) begin
            we_d   = 1'b1;
            bypass = 1'b1;
            out_d  = wb_make_entry(alu_rd_in, alu_data_in);
        end
        fifo_push = alu_live && !bypass;
    end

    wb_fifo #(
        .FIFO_DEPTH_POW (FIFO_DEPTH_POW),
        .T              (wb_entry_t)
    ) u_fifo (
        .clk_i   (clk_in),
        .rst_i   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (wb_make_entry(alu_rd_in, alu_data_in)),
        .head_o  (fifo_head),
        .count_o (fifo_count_out),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_in) begin
        if (reset) begin
            we_q  <= 1'b0;
            out_q <= '0;
        end else begin
            we_q  <= we_d;
            out_q <= out_d;
        end
    end

    assign write_en_out   = we_q;
    assign rd_out         = out_q.rd;
    assign data_write_out = out_q.data;

endmodule : wb_arbiter
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Purpose  : Scoreboard bench for the writeback arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b1;
    logic        alu_valid_in = 1'b0;
    logic [4:0]  alu_rd_in    = '0;
    logic [63:0] alu_data_in  = '0;
    logic        alu_ready_out;
    logic        lsu_valid_in = 1'b0;
    logic [4:0]  lsu_rd_in    = '0;
    logic [63:0] lsu_data_in  = '0;
    logic        write_en_out;
    logic [4:0]  rd_out;
    logic [63:0] data_write_out;
    logic [2:0]  fifo_count_out;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_t;

    exp_t        sbq[$];
    logic [68:0] mq[$];
    logic [4:0]  m_rd;
    logic [63:0] m_data;
    int          n_total = 0;
    int          n_bad   = 0;

    always #5 clk_in = ~clk_in;

    wb_arbiter dut (
        .clk_in         (clk_in),
        .reset          (reset),
        .alu_valid_in   (alu_valid_in),
        .alu_rd_in      (alu_rd_in),
        .alu_data_in    (alu_data_in),
        .alu_ready_out  (alu_ready_out),
        .lsu_valid_in   (lsu_valid_in),
        .lsu_rd_in      (lsu_rd_in),
        .lsu_data_in    (lsu_data_in),
        .write_en_out   (write_en_out),
        .rd_out         (rd_out),
        .data_write_out (data_write_out),
        .fifo_count_out (fifo_count_out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        reset        = 1'b1;
        lsu_valid_in = 1'b1; lsu_rd_in = 5'd6; lsu_data_in = 64'hDEAD;
        alu_valid_in = 1'b1; alu_rd_in = 5'd7; alu_data_in = 64'hBEEF;
        @(posedge clk_in); #1;
        check("rst_we",    64'(write_en_out),   64'd0);
        check("rst_rd",    64'(rd_out),         64'd0);
        check("rst_data",  data_write_out,      64'd0);
        check("rst_count", 64'(fifo_count_out), 64'd0);
        mq.delete();
        sbq.delete();
        m_rd   = '0;
        m_data = '0;
    endtask

    task automatic step(input logic lv, input logic [4:0] lrd, input logic [63:0] ld,
                        input logic av, input logic [4:0] ard, input logic [63:0] ad);
        exp_t        e;
        exp_t        o;
        logic        acc;
        logic        byp;
        @(negedge clk_in);
        reset        = 1'b0;
        lsu_valid_in = lv; lsu_rd_in = lrd; lsu_data_in = ld;
        alu_valid_in = av; alu_rd_in = ard; alu_data_in = ad;
        #1;
        check("ready", 64'(alu_ready_out),  64'(mq.size() < 4));
        check("count", 64'(fifo_count_out), 64'(mq.size()));
        acc    = av && (mq.size() < 4);
        byp    = 1'b0;
        e.we   = 1'b0;
        e.rd   = m_rd;
        e.data = m_data;
        if (lv && lrd != 5'd0) begin
            e.we = 1'b1; e.rd = lrd; e.data = ld;
        end else if (mq.size() != 0) begin
            e.we = 1'b1;
            {e.rd, e.data} = mq.pop_front();
        end else if (acc && ard != 5'd0) begin
            e.we = 1'b1; e.rd = ard; e.data = ad; byp = 1'b1;
        end
        if (acc && ard != 5'd0 && !byp) mq.push_back({ard, ad});
        m_rd   = e.rd;
        m_data = e.data;
        sbq.push_back(e);
        @(posedge clk_in); #1;
        o = sbq.pop_front();
        check("we",   64'(write_en_out), 64'(o.we));
        check("rd",   64'(rd_out),       64'(o.rd));
        check("data", data_write_out,    o.data);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    endtask

    initial begin
        int pushes;
        do_reset();

        // Bypass
        step(1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 64'hAA);
        idle(2);

        // Collision
        step(1'b1, 5'd3, 64'h11, 1'b1, 5'd4, 64'h22);
        idle(3);

        // Backpressure: LSU hogs the port until the queue is full
        for (int i = 0; i < 7; i++)
            step(1'b1, 5'(10 + i), 64'(32'h1000 + i), 1'b1, 5'(20 + i), 64'(32'h2000 + i));
        idle(6);

        // x0 discard
        step(1'b1, 5'd0, 64'h33, 1'b1, 5'd0, 64'h44);
        idle(2);
        step(1'b1, 5'd9, 64'h99, 1'b1, 5'd7, 64'h77);
        step(1'b1, 5'd0, 64'h55, 1'b0, 5'd0, 64'd0);
        idle(2);

        // Reset mid-operation with 3 queued entries
        for (int i = 0; i < 3; i++)
            step(1'b1, 5'd2, 64'(i), 1'b1, 5'(11 + i), 64'(32'hC0 + i));
        do_reset();
        idle(6);

        // Wrap-around: 10 accepted ALU pushes interleaved with LSU stalls
        pushes = 0;
        while (pushes < 10) begin
            if (mq.size() < 4) pushes++;
            step(1'($urandom_range(0, 1)), 5'd30, {$urandom, $urandom},
                 1'b1, 5'(pushes + 1), 64'(32'hA000 + pushes));
        end
        idle(6);

        // Random mix including rd==0 on both sides
        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom},
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom});
        idle(6);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_wb_arbiter
`default_nettype wire
